// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: valid/ready pipelined bitwise gate unit; `LOGIC_GATE_PIPE_COUNT_EN adds an output-transfer counter
module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef LOGIC_GATE_PIPE_COUNT_EN
    output logic [15:0]      count,
`endif
    output logic [WIDTH-1:0] y,
    output logic             zero
);
    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0]             res;
    logic                         stall;
    always_comb begin
        res = op == 3'd0 ? a & b :
              op == 3'd1 ? a | b :
              op == 3'd2 ? a ^ b :
              op == 3'd3 ? ~(a & b) :
              op == 3'd4 ? ~(a | b) :
              op == 3'd5 ? ~(a ^ b) :
              op == 3'd6 ? a & ~b : a;
    end
    assign out_valid = valid_q[STAGES-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall && !rst;
    assign y         = out_valid ? data_q[STAGES-1] : '0;
    assign zero      = out_valid && y == '0;
    // the whole pipe moves or holds as one; bubbles travel as valid=0
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (!stall) begin
            valid_d[0] = in_valid;
            data_d[0]  = res;
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
`ifdef LOGIC_GATE_PIPE_COUNT_EN
    logic [15:0] count_q, count_d;
    always_comb begin
        count_d = count_q + 16'(out_valid && out_ready);
    end
    always_ff @(posedge clk) begin
        count_q <= rst ? '0 : count_d;
    end
    assign count = count_q;
`endif
endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: directed scoreboard bench for logic_gate_pipe (WIDTH=8, STAGES=2)
module tb_logic_gate_pipe;
    localparam int W = 8;
    localparam int S = 2;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
    logic [2:0] op = 0;
    logic [W-1:0] a = 0, b = 0;
    logic in_ready, out_valid, zero;
    logic [W-1:0] y;
`ifdef LOGIC_GATE_PIPE_COUNT_EN
    logic [15:0] count;
`endif
    int nchk = 0, nerr = 0, out_n = 0, got0 = 0, idx = 0, stc = 0, in_n = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] y_s, yh;
    logic ir_s, ov_s, z_s, acc;
    logic [7:0] tbl[8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA0, 8'hA5};

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
`ifdef LOGIC_GATE_PIPE_COUNT_EN
        .count(count),
`endif
        .y(y), .zero(zero)
    );

    function automatic logic [W-1:0] gate(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return x ^ z;
            3'd3: return ~(x & z);
            3'd4: return ~(x | z);
            3'd5: return ~(x ^ z);
            3'd6: return x & ~z;
            default: return x;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [W-1:0] e;
        @(negedge clk);
        ir_s = in_ready;
        ov_s = out_valid;
        y_s  = y;
        z_s  = zero;
        acc  = in_valid && in_ready;
        if (acc) sb.push_back(gate(op, a, b));
        if (!ov_s) chk("y_idle", y_s, 0);
        if (ov_s && out_ready) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_y", y_s, e);
                chk("sb_zero", z_s, e == 0);
            end
            out_n++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset: inputs offered during reset must be refused
        in_valid = 1; a = 8'hFF; b = 8'hFF;
        tick();
        chk("rst_in_ready", ir_s, 0);
        rst = 0; in_valid = 0;
        tick();
        chk("rst_out_valid", ov_s, 0);
        chk("rst_y", y_s, 0);
        chk("rst_zero", z_s, 0);
        chk("rst_discard", sb.size(), 0);
        // single AND, latency two cycles
        op = 3'd0; a = 8'hF0; b = 8'h3C; in_valid = 1;
        tick();
        chk("s1_accept", acc, 1);
        in_valid = 0;
        tick();
        chk("s1_lat1_valid", ov_s, 0);
        tick();
        chk("s1_lat2_valid", ov_s, 1);
        chk("s1_y", y_s, 8'h30);
        chk("s1_zero", z_s, 0);
        // sweep all ops back to back
        for (int t = 0; t < 10; t++) begin
            in_valid = t < 8; op = 3'(t); a = 8'hA5; b = 8'h0F;
            tick();
            if (t < 8) chk("sweep_accept", acc, 1);
            if (t >= 2) begin
                chk("sweep_valid", ov_s, 1);
                chk("sweep_y", y_s, tbl[t-2]);
            end
        end
        in_valid = 0;
        // XOR of equal operands gives zero
        op = 3'd2; a = 8'h5A; b = 8'h5A; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        tick();
        chk("zero_valid", ov_s, 1);
        chk("zero_y", y_s, 0);
        chk("zero_flag", z_s, 1);
        // stream 6 with a 4-cycle consumer stall after the first output
        got0 = out_n; idx = 0; stc = 0;
        for (int k = 0; k < 40 && (idx < 6 || out_n < got0 + 6); k++) begin
            in_valid = idx < 6; op = 3'(idx + 1); a = 8'(idx * 37 + 11); b = 8'(idx * 91 + 5);
            out_ready = !(out_n == got0 + 1 && stc < 4);
            tick();
            if (acc) idx++;
            if (!out_ready) begin
                chk("stall_in_ready", ir_s, 0);
                chk("stall_valid", ov_s, 1);
                if (stc == 0) yh = y_s;
                else chk("stall_y_hold", y_s, yh);
                stc++;
            end
        end
        in_valid = 0; out_ready = 1;
        chk("stall_stalled_4", stc, 4);
        chk("stall_all6", out_n - got0, 6);
        chk("stall_sb_empty", sb.size(), 0);
        // reset while two results are stalled in flight
        out_ready = 0; op = 3'd1; a = 8'h12; b = 8'h40; in_valid = 1;
        tick();
        a = 8'h34;
        tick();
        in_valid = 0;
        tick();
        tick();
        chk("pre_rst_stalled", ov_s, 1);
        rst = 1; in_valid = 1;
        tick();
        chk("mid_rst_in_ready", ir_s, 0);
        sb.delete();
        rst = 0; in_valid = 0; out_ready = 1;
        tick();
        chk("post_rst_valid", ov_s, 0);
        chk("post_rst_y", y_s, 0);
        chk("post_rst_zero", z_s, 0);
`ifdef LOGIC_GATE_PIPE_COUNT_EN
        chk("post_rst_count", count, 0);
`endif
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("no_stale_out", ov_s, 0);
        end
`ifdef LOGIC_GATE_PIPE_COUNT_EN
        // 65537 transfers wrap the counter back to 1
        got0 = out_n; in_n = 0;
        for (int k = 0; k < 70000 && out_n - got0 < 65537; k++) begin
            in_valid = in_n < 65537; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
            tick();
            if (acc) in_n++;
        end
        in_valid = 0;
        chk("count_transfers", out_n - got0, 65537);
        chk("count_wrap", count, 16'(out_n - got0));
`endif
        chk("final_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8, sets the bit width of operands and result; legal range 1..64.
REQ-002 Parameter STAGES, default 2, sets the pipeline depth in register stages; legal range 1..8.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is a synchronous, active-high reset sampled on the rising edge of clk.
REQ-005 Port in_valid  input  1  indicates that a, b and op carry a valid operation.
REQ-006 Port in_ready  output  1  indicates that the block accepts the input in this cycle.
REQ-007 Port op  input  3  selects the gate function.
REQ-008 Port a  input  WIDTH  is the first operand.
REQ-009 Port b  input  WIDTH  is the second operand.
REQ-010 Port out_valid  output  1  indicates that y and zero are valid.
REQ-011 Port out_ready  input  1  indicates that the consumer accepts the output.
REQ-012 Port y  output  WIDTH  is the bitwise result.
REQ-013 Port zero  output  1  is high when y is all zeros and out_valid is high.

Function
REQ-014 The op encoding SHALL be: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 ANDN (a & ~b), 111 PASS (y = a).
REQ-015 An input transfer SHALL occur on a cycle where in_valid and in_ready are both high; an output transfer SHALL occur on a cycle where out_valid and out_ready are both high.
REQ-016 The result SHALL be computed combinationally at entry and carried through STAGES registers, each holding a valid bit and WIDTH data bits.
REQ-017 The stall condition SHALL be out_valid && !out_ready; in_ready SHALL equal !stall, with no combinational path from in_valid to in_ready.
REQ-018 When not stalled, every stage SHALL advance each cycle; stage 0 loads in_valid and the result, and bubbles propagate as valid=0.
REQ-019 When stalled, all stages SHALL hold their contents; no input is accepted and none is lost.
REQ-020 Latency from input transfer to out_valid SHALL be exactly STAGES cycles without a stall; throughput SHALL be one result per cycle.
REQ-021 Results SHALL exit in acceptance order; op is sampled only on an input transfer, so an op change mid-stream affects only later transfers.
REQ-022 While out_valid is high and out_ready is low, y and zero SHALL remain stable.
REQ-023 y SHALL read 0 whenever out_valid is low.

Reset
REQ-024 While rst is high, all stage valid bits SHALL clear, and on the following cycle out_valid=0, y=0 and zero=0.
REQ-025 While rst is high, in_ready SHALL be 0, and any input presented in that cycle is discarded.
REQ-026 A reset asserted mid-operation, including during a stall, SHALL discard all in-flight results, with no output transfer after reset release until a new input is accepted.

Configuration
REQ-027 With macro LOGIC_GATE_PIPE_COUNT_EN defined, the block SHALL add port count output 16 that increments by 1 on each output transfer.
REQ-028 The count port SHALL wrap from 65535 to 0 and SHALL reset to 0.
REQ-029 Without LOGIC_GATE_PIPE_COUNT_EN, the count port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Scenario: WIDTH=8, STAGES=2, out_ready=1; apply op=000, a=0xF0, b=0x3C -> y=0x30 and out_valid=1 two cycles after acceptance, with zero=0.
REQ-031 Scenario: sweep all 8 ops with a=0xA5, b=0x0F -> y = 05, AF, AA, FA, 50, 55, A0, A5 in order, one result per cycle.
REQ-032 Scenario: apply op=010, a=b=0x5A -> y=0x00 and zero=1.
REQ-033 Scenario: stream 6 inputs and hold out_ready=0 for 4 cycles after the first output -> in_ready=0 during the stall, y held stable, all 6 results delivered in order with none dropped or duplicated.
REQ-034 Scenario: assert rst for 1 cycle while 2 results are in flight and stalled -> out_valid=0 the next cycle, no stale output, and count=0 when LOGIC_GATE_PIPE_COUNT_EN is defined.
REQ-035 Scenario: with LOGIC_GATE_PIPE_COUNT_EN defined, preload by streaming 65537 transfers -> count reads 1 after the wrap.
